heap_result_checker: RTL
========================

HEAP_RESULT_CHECKER -- requirements
Module: heap_result_checker

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of captured heap entries.
REQ-002 Parameter DEPTH, default 256, capture memory entries; address width fixed at 8.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 ram_valid  input  1  upstream priority-queue write strobe.
REQ-006 ram_a  input  8  write address from upstream queue.
REQ-007 ram_d  input  DATA_WIDTH  write data from upstream queue.
REQ-008 done_in  input  1  upstream end-of-dump pulse.
REQ-009 rd_req  input  1  readback request.
REQ-010 rd_addr  input  8  readback address.
REQ-011 rd_data  output  DATA_WIDTH  readback data.
REQ-012 rd_valid  output  1  readback data valid.
REQ-013 check_done  output  1  one-cycle pulse, check finished.
REQ-014 heap_ok  output  1  1 = captured image satisfies max-heap property.
REQ-015 err_idx  output  8  first child index violating heap property.
REQ-016 count  output  9  captured entry count (highest written address + 1).
REQ-017 overrun  output  1  sticky: ram_valid seen outside IDLE/CAPTURE.
REQ-018 err_cnt  output  9  number of violating indices.

Function
REQ-019 FSM states IDLE, CAPTURE, CHECK, REPORT; reset state IDLE.
REQ-020 IDLE->CAPTURE on ram_valid; that first write clears count, heap_ok, err_idx, err_cnt, overrun.
REQ-021 CAPTURE: each ram_valid cycle writes mem[ram_a]=ram_d; count=max(count, ram_a+1); duplicate address overwrites; addresses in any order.
REQ-022 ram_valid and done_in in same cycle: write committed, then CAPTURE->CHECK.
REQ-023 done_in in IDLE with no capture: ignored.
REQ-024 CHECK: index i runs 1..count-1, one index per cycle; violation when mem[i] > mem[(i-1)>>1]; compare unsigned.
REQ-025 First violation loads err_idx=i, heap_ok=0; every violation increments err_cnt (saturating at 511).
REQ-026 CHECK->REPORT after i=count-1, or immediately when count<=1 (heap_ok=1); latency count-1 cycles, min 1.
REQ-027 REPORT: check_done=1 one cycle, then IDLE; heap_ok/err_idx/count/err_cnt hold until next capture.
REQ-028 ram_valid in CHECK or REPORT: write dropped, overrun=1.
REQ-029 rd_req accepted in IDLE only: rd_data=mem[rd_addr], rd_valid=1 next cycle; rd_req in other states ignored, rd_valid=0.
REQ-030 rd_addr >= count returns 0.

Reset
REQ-031 rst mid-operation aborts immediately to IDLE.
REQ-032 Reset values: rd_data=0, rd_valid=0, check_done=0, heap_ok=1, err_idx=0, count=0, overrun=0, err_cnt=0.
REQ-033 Memory contents not reset; count=0 makes them unreadable.

Configuration
REQ-034 Macro HEAP_CHK_FULL_SCAN_EN defined: CHECK scans all indices, err_cnt counts all violations.
REQ-035 Macro undefined: CHECK goes to REPORT on first violation; err_cnt is 0 or 1.

Structure
REQ-036 Shared package holds FSM state enum, address width 8, count width 9.
REQ-037 One sub-module heap_chk_mem: single write port, two async read ports (child, parent) plus readback port.

Verification
REQ-038 Write 9,7,8,3,5 to addr 0..4, done_in -> check_done after 4 cycles, heap_ok=1, count=5, err_cnt=0.
REQ-039 Write 9,7,8,10 to 0..3, done_in -> heap_ok=0, err_idx=3, err_cnt=1.
REQ-040 Write single value 42 at addr 0 with done_in same cycle -> heap_ok=1, count=1, check_done after 1 cycle.
REQ-041 Write 1,5,6 to 0..2 -> err_idx=1; err_cnt=2 with HEAP_CHK_FULL_SCAN_EN, 1 without.
REQ-042 ram_valid during CHECK -> overrun=1, memory unchanged; rd_req addr 2 in IDLE -> rd_data=8 next cycle.
REQ-043 rst asserted during CHECK -> outputs at reset values, FSM IDLE, next capture checks normally.

Source files
------------

// File: rtl/heap_result_checker_pkg.sv
// Shared types and widths for the heap result checker.
package heap_result_checker_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned CNT_W  = 9;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_CHECK   = 2'd2,
    ST_REPORT  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] ERR_CNT_MAX = '1;

endpackage

// File: rtl/heap_chk_mem.sv
// Capture memory: one synchronous write port, async child/parent/readback reads.
module heap_chk_mem
  import heap_result_checker_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 256
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_W-1:0]     child_addr,
  output logic [DATA_WIDTH-1:0] child_data,
  input  logic [ADDR_W-1:0]     parent_addr,
  output logic [DATA_WIDTH-1:0] parent_data,
  input  logic [ADDR_W-1:0]     rb_addr,
  output logic [DATA_WIDTH-1:0] rb_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Contents are deliberately not reset; the entry count gates visibility.
  always_ff @(posedge clk) begin
    if (we && (32'(waddr) < DEPTH)) mem[waddr] <= wdata;
  end

  assign child_data  = (32'(child_addr)  < DEPTH) ? mem[child_addr]  : '0;
  assign parent_data = (32'(parent_addr) < DEPTH) ? mem[parent_addr] : '0;
  assign rb_data     = (32'(rb_addr)     < DEPTH) ? mem[rb_addr]     : '0;

endmodule

// File: rtl/heap_result_checker.sv
// Captures a priority-queue memory dump and verifies the max-heap property.
// Define HEAP_CHK_FULL_SCAN_EN to scan every index instead of stopping at the first violation.
module heap_result_checker
  import heap_result_checker_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ram_valid,
  input  logic [ADDR_W-1:0]     ram_a,
  input  logic [DATA_WIDTH-1:0] ram_d,
  input  logic                  done_in,
  input  logic                  rd_req,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  check_done,
  output logic                  heap_ok,
  output logic [ADDR_W-1:0]     err_idx,
  output logic [CNT_W-1:0]      count,
  output logic                  overrun,
  output logic [CNT_W-1:0]      err_cnt
);

  state_t state, state_n;

  logic [ADDR_W-1:0]     chk_idx, chk_idx_n;
  logic [DATA_WIDTH-1:0] child_data, parent_data, rb_data;
  logic [ADDR_W-1:0]     parent_addr;
  logic [CNT_W-1:0]      wr_cnt;
  logic                  mem_we, violation, last_idx, check_active, stop_early;

  logic [DATA_WIDTH-1:0] rd_data_n;
  logic                  rd_valid_n, check_done_n, heap_ok_n, overrun_n;
  logic [ADDR_W-1:0]     err_idx_n;
  logic [CNT_W-1:0]      count_n, err_cnt_n;

  assign mem_we       = ram_valid && (state == ST_IDLE || state == ST_CAPTURE);
  assign wr_cnt       = CNT_W'(ram_a) + CNT_W'(1);
  assign parent_addr  = ADDR_W'((chk_idx - ADDR_W'(1)) >> 1);
  assign violation    = child_data > parent_data;
  assign last_idx     = CNT_W'(chk_idx) == (count - CNT_W'(1));
  assign check_active = (state == ST_CHECK) && (count > CNT_W'(1));

`ifdef HEAP_CHK_FULL_SCAN_EN
  assign stop_early = 1'b0;
`else
  assign stop_early = violation;
`endif

  heap_chk_mem #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk         (clk),
    .we          (mem_we),
    .waddr       (ram_a),
    .wdata       (ram_d),
    .child_addr  (chk_idx),
    .child_data  (child_data),
    .parent_addr (parent_addr),
    .parent_data (parent_data),
    .rb_addr     (rd_addr),
    .rb_data     (rb_data)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:    if (ram_valid) state_n = done_in ? ST_CHECK : ST_CAPTURE;
      ST_CAPTURE: if (done_in) state_n = ST_CHECK;
      ST_CHECK:   if (!check_active || last_idx || stop_early) state_n = ST_REPORT;
      ST_REPORT:  state_n = ST_IDLE;
      default:    state_n = ST_IDLE;
    endcase
  end

  // Next values for the registered outputs and scan index
  always_comb begin
    rd_data_n    = rd_data;
    rd_valid_n   = 1'b0;
    check_done_n = (state == ST_CHECK) && (state_n == ST_REPORT);
    heap_ok_n    = heap_ok;
    err_idx_n    = err_idx;
    count_n      = count;
    overrun_n    = overrun;
    err_cnt_n    = err_cnt;
    chk_idx_n    = ADDR_W'(1);

    if (ram_valid && state == ST_IDLE) begin
      count_n   = wr_cnt;
      heap_ok_n = 1'b1;
      err_idx_n = '0;
      err_cnt_n = '0;
      overrun_n = 1'b0;
    end else if (ram_valid && state == ST_CAPTURE) begin
      if (wr_cnt > count) count_n = wr_cnt;
    end else if (ram_valid) begin
      overrun_n = 1'b1;
    end

    if (check_active) begin
      chk_idx_n = chk_idx + ADDR_W'(1);
      if (violation) begin
        if (heap_ok) err_idx_n = chk_idx;
        heap_ok_n = 1'b0;
        if (err_cnt != ERR_CNT_MAX) err_cnt_n = err_cnt + CNT_W'(1);
      end
    end

    if (rd_req && state == ST_IDLE) begin
      rd_valid_n = 1'b1;
      rd_data_n  = (CNT_W'(rd_addr) < count) ? rb_data : '0;
    end
  end

  // Output and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data    <= '0;
      rd_valid   <= 1'b0;
      check_done <= 1'b0;
      heap_ok    <= 1'b1;
      err_idx    <= '0;
      count      <= '0;
      overrun    <= 1'b0;
      err_cnt    <= '0;
      chk_idx    <= ADDR_W'(1);
    end else begin
      rd_data    <= rd_data_n;
      rd_valid   <= rd_valid_n;
      check_done <= check_done_n;
      heap_ok    <= heap_ok_n;
      err_idx    <= err_idx_n;
      count      <= count_n;
      overrun    <= overrun_n;
      err_cnt    <= err_cnt_n;
      chk_idx    <= chk_idx_n;
    end
  end

endmodule
